// File: rtl/pwm_motor_rampa.sv
`default_nettype none
// ============================================================================
// Module      : pwm_motor_rampa
// Description : Receiving end of the ramp-start stage interface. Synchronises
//               the one-hot speed stage lines (30/50/100 %) from the ramp FSM
//               into clk, slews the motor duty toward the commanded stage and
//               drives a glitch-free PWM output. Multi-hot stage codes trigger
//               an immediate emergency stop and a sticky fault flag.
// Ports       : clk        - system clock
//               reset_n    - asynchronous reset, active low
//               in_30      - stage 30 % request (asynchronous to clk)
//               in_50      - stage 50 % request (asynchronous to clk)
//               in_100     - stage 100 % request (asynchronous to clk)
//               pwm_out    - registered motor PWM drive
//               duty       - current slewed duty, 0..100 %
//               at_target  - duty equals decoded target
//               running    - duty is nonzero
//               fault      - sticky illegal-stage flag
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_motor_rampa #(
  parameter int PWM_DIV  = 1,
  parameter int STEP_DIV = 1000,
  parameter int STEP     = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_30,
  input  logic       in_50,
  input  logic       in_100,
  output logic       pwm_out,
  output logic [6:0] duty,
  output logic       at_target,
  output logic       running,
  output logic       fault
);

  localparam int c_PRE_W  = (PWM_DIV  > 1) ? $clog2(PWM_DIV)  : 1;
  localparam int c_STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [c_PRE_W-1:0]  c_PRE_LAST  = c_PRE_W'(PWM_DIV - 1);
  localparam logic [c_STEP_W-1:0] c_STEP_LAST = c_STEP_W'(STEP_DIV - 1);
  localparam logic [7:0]          c_STEP8     = 8'(STEP);
  localparam logic [6:0]          c_STEP7     = 7'(STEP);
  localparam logic [6:0]          c_PWM_LAST  = 7'd99;

  logic [2:0]          r_sync1;
  logic [2:0]          r_sync2;
  logic [6:0]          r_target;
  logic [6:0]          r_duty;
  logic [6:0]          r_duty_lat;
  logic [c_PRE_W-1:0]  r_pre;
  logic [c_STEP_W-1:0] r_step_cnt;
  logic [6:0]          r_pwm_cnt;
  logic                r_pwm_out;
  logic                r_fault;

  logic       w_illegal;
  logic [6:0] w_decoded;
  logic       w_step_tick;
  logic       w_pre_tc;
  logic       w_wrap;
  logic [7:0] w_diff_up;
  logic [7:0] w_diff_dn;
  logic [6:0] w_duty_next;

  // Stage decode of the synchronised code {in_100, in_50, in_30}
  always_comb begin
    w_illegal = 1'b0;
    w_decoded = 7'd0;
    case (r_sync2)
      3'b000:  w_decoded = 7'd0;
      3'b001:  w_decoded = 7'd30;
      3'b010:  w_decoded = 7'd50;
      3'b100:  w_decoded = 7'd100;
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_step_tick = (r_step_cnt == c_STEP_LAST);
  assign w_pre_tc    = (r_pre == c_PRE_LAST);
  assign w_wrap      = w_pre_tc && (r_pwm_cnt == c_PWM_LAST);

  // Slew toward target by STEP, clamping on the final step so the ramp
  // never overshoots or underflows. Differences are taken in 8 bits.
  assign w_diff_up = {1'b0, r_target} - {1'b0, r_duty};
  assign w_diff_dn = {1'b0, r_duty} - {1'b0, r_target};

  always_comb begin
    w_duty_next = r_duty;
    if (r_target > r_duty) begin
      w_duty_next = (w_diff_up <= c_STEP8) ? r_target : (r_duty + c_STEP7);
    end else if (r_target < r_duty) begin
      w_duty_next = (w_diff_dn <= c_STEP8) ? r_target : (r_duty - c_STEP7);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1    <= 3'b000;
      r_sync2    <= 3'b000;
      r_target   <= 7'd0;
      r_duty     <= 7'd0;
      r_duty_lat <= 7'd0;
      r_pre      <= '0;
      r_step_cnt <= '0;
      r_pwm_cnt  <= 7'd0;
      r_pwm_out  <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_sync1 <= {in_100, in_50, in_30};
      r_sync2 <= r_sync1;

      // Fault is sticky until the line is idle and the motor has stopped;
      // while it is set, legal nonzero stages are ignored.
      if (w_illegal) begin
        r_fault <= 1'b1;
      end else if ((r_sync2 == 3'b000) && (r_duty == 7'd0)) begin
        r_fault <= 1'b0;
      end

      r_target <= (w_illegal || r_fault) ? 7'd0 : w_decoded;

      r_step_cnt <= w_step_tick ? '0 : r_step_cnt + 1'b1;
      r_pre      <= w_pre_tc ? '0 : r_pre + 1'b1;
      if (w_pre_tc) begin
        r_pwm_cnt <= (r_pwm_cnt == c_PWM_LAST) ? 7'd0 : r_pwm_cnt + 7'd1;
      end

      // Emergency stop overrides both the slew and the period latch
      if (w_illegal) begin
        r_duty     <= 7'd0;
        r_duty_lat <= 7'd0;
      end else begin
        if (w_step_tick) begin
          r_duty <= w_duty_next;
        end
        // Duty only reaches the comparator at the period boundary
        if (w_wrap) begin
          r_duty_lat <= r_duty;
        end
      end

      r_pwm_out <= !w_illegal && (r_pwm_cnt < r_duty_lat);
    end
  end

  assign pwm_out   = r_pwm_out;
  assign duty      = r_duty;
  assign fault     = r_fault;
  assign at_target = (r_duty == r_target);
  assign running   = (r_duty != 7'd0);

endmodule
`default_nettype wire

// File: tb/tb_pwm_motor_rampa.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_motor_rampa
// Description : Directed self-checking bench for pwm_motor_rampa. One instance
//               uses STEP=5, a second uses STEP=7 for the clamped ramp and
//               mid-ramp retarget scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_motor_rampa;

  logic       clk = 1'b0;
  logic       reset_n, in_30, in_50, in_100;
  logic       pwm_out, at_target, running, fault;
  logic [6:0] duty;

  logic       reset7_n, a_30, a_50, a_100;
  logic       pwm_out7, at_target7, running7, fault7;
  logic [6:0] duty7;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pwm_motor_rampa #(.PWM_DIV(1), .STEP_DIV(4), .STEP(5)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_30     (in_30),
    .in_50     (in_50),
    .in_100    (in_100),
    .pwm_out   (pwm_out),
    .duty      (duty),
    .at_target (at_target),
    .running   (running),
    .fault     (fault)
  );

  pwm_motor_rampa #(.PWM_DIV(1), .STEP_DIV(4), .STEP(7)) u_dut7 (
    .clk       (clk),
    .reset_n   (reset7_n),
    .in_30     (a_30),
    .in_50     (a_50),
    .in_100    (a_100),
    .pwm_out   (pwm_out7),
    .duty      (duty7),
    .at_target (at_target7),
    .running   (running7),
    .fault     (fault7)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the selected instance's duty to move, then check it
  task automatic wait_change(input bit sel, input int exp, input string tag);
    logic [6:0] old;
    old = sel ? duty7 : duty;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((sel ? duty7 : duty) != old) break;
    end
    check(tag, int'(sel ? duty7 : duty), exp);
  endtask

  task automatic wait_duty(input int val, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (int'(duty) == val) break;
      @(negedge clk);
    end
    check(tag, int'(duty), val);
  endtask

  task automatic count_high(output int n);
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (pwm_out) n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int hi;

    // ---- 1: reset with random inputs, then idle ----
    reset_n = 1'b0; reset7_n = 1'b0;
    {a_100, a_50, a_30} = 3'b000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      {in_100, in_50, in_30} = 3'($urandom_range(0, 7));
    end
    @(negedge clk);
    check("rst_pwm_out", int'(pwm_out), 0);
    check("rst_duty", int'(duty), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_running", int'(running), 0);
    check("rst_at_target", int'(at_target), 1);
    {in_100, in_50, in_30} = 3'b000;
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (duty != 7'd0 || pwm_out || fault || running || !at_target) bad++;
    end
    check("idle_stable_bad_cycles", bad, 0);

    // ---- 2: ramp to 30 ----
    in_30 = 1'b1;
    @(negedge clk); @(negedge clk);
    check("t2_target_not_yet", int'(at_target), 1);
    @(negedge clk);
    check("t2_target_after_3clk", int'(at_target), 0);
    for (int k = 1; k <= 6; k++) wait_change(1'b0, 5 * k, $sformatf("t2_duty_%0d", k));
    check("t2_at_target", int'(at_target), 1);
    repeat (200) @(negedge clk);
    count_high(hi);
    check("t2_pwm_high_30", hi, 30);

    // ---- 3: 30 -> 100 -> 0 ----
    in_30 = 1'b0; in_100 = 1'b1;
    for (int k = 1; k <= 14; k++) wait_change(1'b0, 30 + 5 * k, $sformatf("t3_duty_up_%0d", k));
    repeat (200) @(negedge clk);
    count_high(hi);
    check("t3_pwm_high_100", hi, 100);
    in_100 = 1'b0;
    wait_change(1'b0, 95, "t3_duty_down_first");
    wait_duty(0, 400, "t3_duty_zero");
    check("t3_running", int'(running), 0);
    check("t3_at_target", int'(at_target), 1);

    // ---- 4: STEP=7 ramp with mid-ramp retarget, then clamp down to 30 ----
    @(negedge clk);
    reset7_n = 1'b1;
    repeat (5) @(negedge clk);
    a_30 = 1'b1;
    wait_change(1'b1, 7, "t4_duty_7");
    wait_change(1'b1, 14, "t4_duty_14");
    a_30 = 1'b0; a_50 = 1'b1;
    wait_change(1'b1, 21, "t4_duty_21");
    wait_change(1'b1, 28, "t4_duty_28");
    wait_change(1'b1, 35, "t4_duty_35");
    wait_change(1'b1, 42, "t4_duty_42");
    wait_change(1'b1, 49, "t4_duty_49");
    wait_change(1'b1, 50, "t4_duty_50_clamped");
    repeat (40) @(negedge clk);
    check("t4_no_overshoot", int'(duty7), 50);
    check("t4_at_target", int'(at_target7), 1);
    a_50 = 1'b0; a_30 = 1'b1;
    wait_change(1'b1, 43, "t4_down_43");
    wait_change(1'b1, 36, "t4_down_36");
    wait_change(1'b1, 30, "t4_down_30_clamped");

    // ---- 5: illegal code emergency stop ----
    in_50 = 1'b1;
    wait_duty(50, 200, "t5_duty_50");
    repeat (300) @(negedge clk);
    in_30 = 1'b1;
    @(negedge clk); @(negedge clk);
    check("t5_fault_not_yet", int'(fault), 0);
    @(negedge clk);
    check("t5_fault_set", int'(fault), 1);
    check("t5_duty_zero", int'(duty), 0);
    @(negedge clk);
    check("t5_pwm_low", int'(pwm_out), 0);
    in_30 = 1'b0;
    repeat (30) @(negedge clk);
    check("t5_legal_ignored_duty", int'(duty), 0);
    check("t5_fault_sticky", int'(fault), 1);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (pwm_out) bad++;
    end
    check("t5_pwm_stays_low", bad, 0);
    in_50 = 1'b0;
    repeat (5) @(negedge clk);
    check("t5_fault_cleared", int'(fault), 0);

    // ---- 6: async reset mid-ramp ----
    in_100 = 1'b1;
    wait_duty(45, 200, "t6_duty_45");
    #2 reset_n = 1'b0;
    #1;
    check("t6_async_duty", int'(duty), 0);
    check("t6_async_pwm", int'(pwm_out), 0);
    check("t6_async_running", int'(running), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_change(1'b0, 5, "t6_restart_5");
    wait_change(1'b0, 10, "t6_restart_10");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
